// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: holds the PC, issues one icache request at a
// time, queries the branch predictor with each returned instruction and
// hands {inst, pc, prediction} to the decoder. ROB rollback redirects the PC
// and drops any response still in flight.
module fetch_controller #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    output logic                  icache_req_valid,
    input  logic                  icache_req_ready,
    output logic [ADDR_WIDTH-1:0] icache_req_pc,
    input  logic                  icache_resp_valid,
    input  logic [INST_WIDTH-1:0] icache_resp_inst,
    output logic [ADDR_WIDTH-1:0] pred_query_pc,
    output logic [INST_WIDTH-1:0] pred_query_inst,
    input  logic                  pred_jump,
    input  logic [ADDR_WIDTH-1:0] pred_target_pc,
    input  logic                  dec_full,
    output logic                  dec_valid,
    output logic [INST_WIDTH-1:0] dec_inst,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    output logic                  dec_pred_jump,
    input  logic                  rollback_valid,
    input  logic [ADDR_WIDTH-1:0] rollback_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_discard;
    logic [INST_WIDTH-1:0] r_hold_inst;
    logic                  r_hold_jump;
    logic [ADDR_WIDTH-1:0] r_hold_next_pc;
    logic                  r_dec_valid;
    logic [INST_WIDTH-1:0] r_dec_inst;
    logic [ADDR_WIDTH-1:0] r_dec_pc;
    logic                  r_dec_pred_jump;

    state_t                w_state_n;
    logic [ADDR_WIDTH-1:0] w_pc_n;
    logic                  w_discard_n;
    logic [INST_WIDTH-1:0] w_hold_inst_n;
    logic                  w_hold_jump_n;
    logic [ADDR_WIDTH-1:0] w_hold_next_pc_n;
    logic                  w_dec_valid_n;
    logic [INST_WIDTH-1:0] w_dec_inst_n;
    logic [ADDR_WIDTH-1:0] w_dec_pc_n;
    logic                  w_dec_pred_jump_n;
    logic                  w_req_valid;
    logic [ADDR_WIDTH-1:0] w_next_pc;

    assign w_req_valid      = rdy && (r_state == IDLE) && !rollback_valid;
    assign icache_req_valid = w_req_valid;
    assign icache_req_pc    = r_pc;

    // The PC is only advanced on delivery, so it still names the instruction under prediction.
    assign pred_query_pc   = r_pc;
    assign pred_query_inst = (r_state == HOLD) ? r_hold_inst : icache_resp_inst;
    assign w_next_pc       = pred_jump ? pred_target_pc : r_pc + ADDR_WIDTH'(4);

    assign dec_valid     = r_dec_valid;
    assign dec_inst      = r_dec_inst;
    assign dec_pc        = r_dec_pc;
    assign dec_pred_jump = r_dec_pred_jump;

    // Next-state, next-PC and delivery decisions; rollback overrides everything.
    always_comb begin
        w_state_n         = r_state;
        w_pc_n            = r_pc;
        w_discard_n       = r_discard;
        w_hold_inst_n     = r_hold_inst;
        w_hold_jump_n     = r_hold_jump;
        w_hold_next_pc_n  = r_hold_next_pc;
        w_dec_valid_n     = 1'b0;
        w_dec_inst_n      = r_dec_inst;
        w_dec_pc_n        = r_dec_pc;
        w_dec_pred_jump_n = r_dec_pred_jump;
        if (rollback_valid) begin
            w_state_n = IDLE;
            w_pc_n    = rollback_pc;
            // A WAIT without a response this cycle leaves a stale response in flight.
            if (r_state == WAIT) begin
                w_discard_n = !icache_resp_valid;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req_valid && icache_req_ready) begin
                        w_state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (icache_resp_valid) begin
                        if (r_discard) begin
                            w_discard_n = 1'b0;
                            w_state_n   = IDLE;
                        end else if (!dec_full) begin
                            w_dec_valid_n     = 1'b1;
                            w_dec_inst_n      = icache_resp_inst;
                            w_dec_pc_n        = r_pc;
                            w_dec_pred_jump_n = pred_jump;
                            w_pc_n            = w_next_pc;
                            w_state_n         = IDLE;
                        end else begin
                            w_hold_inst_n    = icache_resp_inst;
                            w_hold_jump_n    = pred_jump;
                            w_hold_next_pc_n = w_next_pc;
                            w_state_n        = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!dec_full) begin
                        w_dec_valid_n     = 1'b1;
                        w_dec_inst_n      = r_hold_inst;
                        w_dec_pc_n        = r_pc;
                        w_dec_pred_jump_n = r_hold_jump;
                        w_pc_n            = r_hold_next_pc;
                        w_state_n         = IDLE;
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    // State registers: synchronous reset, frozen while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_pc            <= RESET_PC;
            r_discard       <= 1'b0;
            r_hold_inst     <= '0;
            r_hold_jump     <= 1'b0;
            r_hold_next_pc  <= '0;
            r_dec_valid     <= 1'b0;
            r_dec_inst      <= '0;
            r_dec_pc        <= '0;
            r_dec_pred_jump <= 1'b0;
        end else if (rdy) begin
            r_state         <= w_state_n;
            r_pc            <= w_pc_n;
            r_discard       <= w_discard_n;
            r_hold_inst     <= w_hold_inst_n;
            r_hold_jump     <= w_hold_jump_n;
            r_hold_next_pc  <= w_hold_next_pc_n;
            r_dec_valid     <= w_dec_valid_n;
            r_dec_inst      <= w_dec_inst_n;
            r_dec_pc        <= w_dec_pc_n;
            r_dec_pred_jump <= w_dec_pred_jump_n;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Cycle-by-cycle vector bench for fetch_controller: each row gives the
// inputs for one cycle and the outputs expected just after they settle.
module tb_fetch_controller;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] JAL = 32'h0080_006F;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        icache_req_valid, icache_req_ready;
    logic [31:0] icache_req_pc;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_inst;
    logic [31:0] pred_query_pc, pred_query_inst;
    logic        pred_jump;
    logic [31:0] pred_target_pc;
    logic        dec_full, dec_valid;
    logic [31:0] dec_inst, dec_pc;
    logic        dec_pred_jump;
    logic        rollback_valid;
    logic [31:0] rollback_pc;

    fetch_controller #(.ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
        .icache_req_pc(icache_req_pc),
        .icache_resp_valid(icache_resp_valid), .icache_resp_inst(icache_resp_inst),
        .pred_query_pc(pred_query_pc), .pred_query_inst(pred_query_inst),
        .pred_jump(pred_jump), .pred_target_pc(pred_target_pc),
        .dec_full(dec_full), .dec_valid(dec_valid), .dec_inst(dec_inst),
        .dec_pc(dec_pc), .dec_pred_jump(dec_pred_jump),
        .rollback_valid(rollback_valid), .rollback_pc(rollback_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, rdy, rq, rv;
        logic [31:0] inst;
        logic        pj;
        logic [31:0] pt;
        logic        full, rb;
        logic [31:0] rbpc;
        logic        e_rqv;
        logic [31:0] e_rqpc;
        logic        e_dv;
        logic [31:0] e_dpc, e_dinst;
        logic        e_dj;
        logic        e_q;
        logic [31:0] e_qpc;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic vec(input logic r, input logic rd, input logic rq, input logic rv,
                       input logic [31:0] inst, input logic pj, input logic [31:0] pt,
                       input logic full, input logic rb, input logic [31:0] rbpc,
                       input logic erqv, input logic [31:0] erqpc,
                       input logic edv, input logic [31:0] edpc, input logic [31:0] edinst,
                       input logic edj, input logic eq, input logic [31:0] eqpc);
        vec_t v;
        v.rst = r; v.rdy = rd; v.rq = rq; v.rv = rv; v.inst = inst; v.pj = pj; v.pt = pt;
        v.full = full; v.rb = rb; v.rbpc = rbpc; v.e_rqv = erqv; v.e_rqpc = erqpc;
        v.e_dv = edv; v.e_dpc = edpc; v.e_dinst = edinst; v.e_dj = edj; v.e_q = eq; v.e_qpc = eqpc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    initial begin
        // Idle-cycle helpers: only req/delivery expectations differ per row.
        //   rst rdy rq rv inst pj pt full rb rbpc | rqv rqpc | dv dpc dinst dj | q qpc
        // Test 1: nop stream with one-cycle icache latency
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'h0,          0,0,0,0,          0,0);
        vec(0,1,0,1,NOP,0,0,0,0,0,          0,0,              0,0,0,0,          1,32'h0);
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'h4,          1,32'h0,NOP,0,    0,0);
        vec(0,1,0,1,NOP,0,0,0,0,0,          0,0,              0,0,0,0,          1,32'h4);
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'h8,          1,32'h4,NOP,0,    0,0);
        vec(0,1,0,1,NOP,0,0,0,0,0,          0,0,              0,0,0,0,          1,32'h8);
        vec(0,1,0,0,0,0,0,0,0,0,            1,32'hC,          1,32'h8,NOP,0,    0,0);
        // Rollback in IDLE masks the request and redirects to 0x100
        vec(0,1,1,0,0,0,0,0,1,32'h100,      0,0,              0,0,0,0,          0,0);
        // Test 2: predicted-taken jal
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'h100,        0,0,0,0,          0,0);
        vec(0,1,0,1,JAL,1,32'h108,0,0,0,    0,0,              0,0,0,0,          1,32'h100);
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'h108,        1,32'h100,JAL,1,  0,0);
        // Test 3: decoder full for 5 cycles, spurious response while holding
        vec(0,1,0,1,NOP,0,0,1,0,0,          0,0,              0,0,0,0,          1,32'h108);
        vec(0,1,1,0,0,0,0,1,0,0,            0,0,              0,0,0,0,          0,0);
        vec(0,1,1,1,BAD,0,0,1,0,0,          0,0,              0,0,0,0,          0,0);
        vec(0,1,1,0,0,0,0,1,0,0,            0,0,              0,0,0,0,          0,0);
        vec(0,1,1,0,0,0,0,1,0,0,            0,0,              0,0,0,0,          0,0);
        vec(0,1,0,0,0,0,0,0,0,0,            0,0,              0,0,0,0,          0,0);
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'h10C,        1,32'h108,NOP,0,  0,0);
        // Test 4: rollback in WAIT, stale response two cycles later is dropped
        vec(0,1,0,0,0,0,0,0,1,32'h200,      0,0,              0,0,0,0,          0,0);
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'h200,        0,0,0,0,          0,0);
        vec(0,1,0,1,BAD,0,0,0,0,0,          0,0,              0,0,0,0,          0,0);
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'h200,        0,0,0,0,          0,0);
        vec(0,1,0,1,NOP,0,0,0,0,0,          0,0,              0,0,0,0,          1,32'h200);
        vec(0,1,0,0,0,0,0,0,0,0,            1,32'h204,        1,32'h200,NOP,0,  0,0);
        // Test 5: rollback coinciding with a response, then rdy low mid-WAIT
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'h204,        0,0,0,0,          0,0);
        vec(0,1,0,1,NOP,0,0,0,1,32'h200,    0,0,              0,0,0,0,          0,0);
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'h200,        0,0,0,0,          0,0);
        vec(0,0,1,0,0,0,0,0,0,0,            0,0,              0,0,0,0,          0,0);
        vec(0,0,1,0,0,0,0,0,0,0,            0,0,              0,0,0,0,          0,0);
        vec(0,0,1,0,0,0,0,0,0,0,            0,0,              0,0,0,0,          0,0);
        vec(0,1,0,1,NOP,0,0,0,0,0,          0,0,              0,0,0,0,          1,32'h200);
        // rdy low right after delivery: request forced off, dec_valid held
        vec(0,0,1,0,0,0,0,0,0,0,            0,0,              1,32'h200,NOP,0,  0,0);
        vec(0,0,1,0,0,0,0,0,0,0,            0,0,              1,32'h200,NOP,0,  0,0);
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'h204,        1,32'h200,NOP,0,  0,0);
        vec(0,1,0,1,NOP,0,0,0,0,0,          0,0,              0,0,0,0,          1,32'h204);
        // Test 6: PC wrap from 0xFFFFFFFC
        vec(0,1,1,0,0,0,0,0,1,32'hFFFFFFFC, 0,0,              1,32'h204,NOP,0,  0,0);
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'hFFFFFFFC,   0,0,0,0,          0,0);
        vec(0,1,0,1,NOP,0,0,0,0,0,          0,0,              0,0,0,0,          1,32'hFFFFFFFC);
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'h0,          1,32'hFFFFFFFC,NOP,0, 0,0);
        vec(0,1,0,1,NOP,0,0,0,0,0,          0,0,              0,0,0,0,          1,32'h0);
        vec(0,1,1,0,0,0,0,0,0,0,            1,32'h4,          1,32'h0,NOP,0,    0,0);
        // Reset while WAIT at pc 0x4; late response afterwards is ignored
        vec(1,1,0,0,0,0,0,0,0,0,            0,0,              0,0,0,0,          0,0);
        vec(0,1,0,1,BAD,0,0,0,0,0,          1,32'h0,          0,0,0,0,          0,0);
        vec(0,1,0,0,0,0,0,0,0,0,            1,32'h0,          0,0,0,0,          0,0);

        rst = 1'b1; rdy = 1'b1; icache_req_ready = 1'b0; icache_resp_valid = 1'b0;
        icache_resp_inst = '0; pred_jump = 1'b0; pred_target_pc = '0; dec_full = 1'b0;
        rollback_valid = 1'b0; rollback_pc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        chk("reset_req_valid", -1, 32'(icache_req_valid), 32'd1);
        chk("reset_req_pc",    -1, icache_req_pc, 32'h0);
        chk("reset_dec_valid", -1, 32'(dec_valid), 32'd0);
        chk("reset_dec_pc",    -1, dec_pc, 32'h0);
        chk("reset_dec_inst",  -1, dec_inst, 32'h0);
        chk("reset_dec_jump",  -1, 32'(dec_pred_jump), 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst               = vecs[i].rst;
            rdy               = vecs[i].rdy;
            icache_req_ready  = vecs[i].rq;
            icache_resp_valid = vecs[i].rv;
            icache_resp_inst  = vecs[i].inst;
            pred_jump         = vecs[i].pj;
            pred_target_pc    = vecs[i].pt;
            dec_full          = vecs[i].full;
            rollback_valid    = vecs[i].rb;
            rollback_pc       = vecs[i].rbpc;
            #1;
            n_vec++;
            chk("req_valid", i, 32'(icache_req_valid), 32'(vecs[i].e_rqv));
            if (vecs[i].e_rqv)
                chk("req_pc", i, icache_req_pc, vecs[i].e_rqpc);
            chk("dec_valid", i, 32'(dec_valid), 32'(vecs[i].e_dv));
            if (vecs[i].e_dv) begin
                chk("dec_pc",   i, dec_pc, vecs[i].e_dpc);
                chk("dec_inst", i, dec_inst, vecs[i].e_dinst);
                chk("dec_jump", i, 32'(dec_pred_jump), 32'(vecs[i].e_dj));
            end
            if (vecs[i].e_q) begin
                chk("query_pc",   i, pred_query_pc, vecs[i].e_qpc);
                chk("query_inst", i, pred_query_inst, vecs[i].inst);
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
